md5_search_ctrl: RTL and testbench

- Brute-force search sequencer for the fully pipelined MD5 core (64 round stages, one message accepted per clock, fixed latency).
- Enumerates fixed-length candidate strings over a configurable byte range and issues one candidate per cycle into the core.
- Tracks which pipeline slots hold valid candidates, compares each emerging digest to a target, and reports the first matching preimage.
- Sits between the host/config registers and one md5core instance.

---
 rtl/md5_search_pkg.sv | 19 +
 rtl/md5_cand_odometer.sv | 55 +++++
 rtl/md5_search_ctrl.sv | 164 ++++++++++++++++
 tb/tb_md5_search_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_search_pkg.sv
// Shared types and constants for the MD5 brute-force search controller.
// Pipeline depth of the attached core and the maximum candidate length live here.
package md5_search_pkg;

  localparam int MD5_PIPE_LAT = 66;
  localparam int MAX_LEN      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [63:0] len_to_bits(input logic [3:0] len);
    return {57'd0, len, 3'd0};
  endfunction

endpackage

// File: rtl/md5_cand_odometer.sv
// MAX_LEN-byte odometer: byte 0 counts fastest, each active byte wraps hi->lo and carries.
// Bytes at or above the active length stay zero; o_last flags the all-hi candidate.
module md5_cand_odometer
  import md5_search_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_adv,
  input  logic [3:0]           i_len,
  input  logic [7:0]           i_lo,
  input  logic [7:0]           i_hi,
  output logic [8*MAX_LEN-1:0] o_cand,
  output logic                 o_last
);

  logic [MAX_LEN-1:0][7:0] r_byte;
  logic [MAX_LEN-1:0][7:0] w_next;
  logic                    w_carry;
  logic                    w_last;

  always_comb begin
    w_next  = r_byte;
    w_carry = 1'b1;
    w_last  = 1'b1;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (j < int'(i_len)) begin
        if (r_byte[j] != i_hi) w_last = 1'b0;
        if (w_carry) begin
          if (r_byte[j] == i_hi) begin
            w_next[j] = i_lo;
          end else begin
            w_next[j] = r_byte[j] + 8'd1;
            w_carry   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte <= '0;
    end else if (i_load) begin
      for (int j = 0; j < MAX_LEN; j++)
        r_byte[j] <= (j < int'(i_len)) ? i_lo : 8'd0;
    end else if (i_adv) begin
      r_byte <= w_next;
    end
  end

  assign o_cand = r_byte;
  assign o_last = w_last;

endmodule

// File: rtl/md5_search_ctrl.sv
// Issues one candidate per cycle into a fixed-latency MD5 pipeline and reports the first
// candidate whose digest equals the target; a valid shift register tracks occupied slots.
module md5_search_ctrl
  import md5_search_pkg::*;
#(
  parameter int PIPE_LAT = MD5_PIPE_LAT,
  parameter int CNT_W    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cfg_len,
  input  logic [7:0]       cfg_char_lo,
  input  logic [7:0]       cfg_char_hi,
  input  logic [127:0]     cfg_target,
  output logic [447:0]     core_message,
  output logic [63:0]      core_length,
  input  logic [127:0]     core_hash,
  input  logic [511:0]     core_msg_out,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [63:0]      found_msg,
  output logic             cfg_err,
  output logic [CNT_W-1:0] tried_count
);

  state_t              r_state;
  logic [3:0]          r_len;
  logic [7:0]          r_lo;
  logic [7:0]          r_hi;
  logic [127:0]        r_target;
  logic [447:0]        r_core_msg;
  logic [63:0]         r_core_len;
  logic                r_issue;
  logic [PIPE_LAT-1:0] r_vld_sr;
  logic                r_busy;
  logic                r_done;
  logic                r_found;
  logic [63:0]         r_found_msg;
  logic                r_cfg_err;
  logic [CNT_W-1:0]    r_tried;

  logic                w_idle;
  logic                w_cfg_ok;
  logic                w_load;
  logic                w_match;
  logic                w_issue;
  logic [3:0]          w_od_len;
  logic [7:0]          w_od_lo;
  logic [7:0]          w_od_hi;
  logic [8*MAX_LEN-1:0] w_cand;
  logic                w_od_last;
  logic [6:0]          w_shamt;
  logic                w_unused;

  assign w_idle   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_cfg_ok = (cfg_len != 4'd0) && (cfg_len <= 4'(MAX_LEN)) && (cfg_char_lo <= cfg_char_hi);
  assign w_load   = w_idle && start && w_cfg_ok;

  // r_issue marks the core_message register; the shift register then follows the core's
  // pipeline so its tail lines up with the digest of that same message.
  assign w_match  = r_vld_sr[PIPE_LAT-1] && (core_hash == r_target) && !r_found;
  assign w_issue  = (r_state == ST_RUN) && !w_match;

  assign w_od_len = w_load ? cfg_len     : r_len;
  assign w_od_lo  = w_load ? cfg_char_lo : r_lo;
  assign w_od_hi  = w_load ? cfg_char_hi : r_hi;
  assign w_shamt  = 7'd64 - {r_len, 3'd0};
  assign w_unused = ^core_msg_out[447:0];

  md5_cand_odometer u_odo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_adv  (w_issue),
    .i_len  (w_od_len),
    .i_lo   (w_od_lo),
    .i_hi   (w_od_hi),
    .o_cand (w_cand),
    .o_last (w_od_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_target    <= '0;
      r_core_msg  <= '0;
      r_core_len  <= '0;
      r_issue     <= 1'b0;
      r_vld_sr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_found_msg <= '0;
      r_cfg_err   <= 1'b0;
      r_tried     <= '0;
    end else begin
      r_vld_sr <= {r_vld_sr[PIPE_LAT-2:0], r_issue};
      r_issue  <= w_issue;

      if (w_issue) begin
        r_core_msg <= {{(448-8*MAX_LEN){1'b0}}, w_cand};
        r_core_len <= len_to_bits(r_len);
        if (r_tried != '1) r_tried <= r_tried + 1'b1;
      end

      if (w_match) begin
        r_found     <= 1'b1;
        r_found_msg <= core_msg_out[511:448] >> w_shamt;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_found     <= 1'b0;
            r_found_msg <= '0;
            r_tried     <= '0;
            if (w_cfg_ok) begin
              r_state   <= ST_RUN;
              r_len     <= cfg_len;
              r_lo      <= cfg_char_lo;
              r_hi      <= cfg_char_hi;
              r_target  <= cfg_target;
              r_cfg_err <= 1'b0;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
            end else begin
              r_state   <= ST_DONE;
              r_cfg_err <= 1'b1;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_match || abort || (w_issue && w_od_last)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((r_vld_sr == '0) && !r_issue) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_message = r_core_msg;
  assign core_length  = r_core_len;
  assign busy         = r_busy;
  assign done         = r_done;
  assign found        = r_found;
  assign found_msg    = r_found_msg;
  assign cfg_err      = r_cfg_err;
  assign tried_count  = r_tried;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl: a behavioural MD5 pipeline stands in for the core, and each search
// is predicted from candidate enumeration in base (hi-lo+1) plus the pipeline depth.
module tb_md5_search_ctrl;
  import md5_search_pkg::*;

  localparam int LAT = MD5_PIPE_LAT;
  localparam int S_TAB[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [3:0]   cfg_len;
  logic [7:0]   cfg_char_lo;
  logic [7:0]   cfg_char_hi;
  logic [127:0] cfg_target;
  logic [447:0] core_message;
  logic [63:0]  core_length;
  logic [127:0] core_hash;
  logic [511:0] core_msg_out;
  logic         busy;
  logic         done;
  logic         found;
  logic [63:0]  found_msg;
  logic         cfg_err;
  logic [47:0]  tried_count;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0]  K_TAB[64];
  logic [127:0] h_pipe[LAT];
  logic [511:0] m_pipe[LAT];
  bit           force_en;
  logic [63:0]  force_a;
  logic [63:0]  force_b;
  logic [127:0] force_tgt;

  md5_search_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_len      (cfg_len),
    .cfg_char_lo  (cfg_char_lo),
    .cfg_char_hi  (cfg_char_hi),
    .cfg_target   (cfg_target),
    .core_message (core_message),
    .core_length  (core_length),
    .core_hash    (core_hash),
    .core_msg_out (core_msg_out),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .found_msg    (found_msg),
    .cfg_err      (cfg_err),
    .tried_count  (tried_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    real x;
    for (int i = 0; i < 64; i++) begin
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      K_TAB[i] = 32'(longint'($floor(x * 4294967296.0)));
    end
  end

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // MD5 padded block: first string character in the top byte, bit length little-endian at the end.
  function automatic logic [511:0] build_block(input logic [447:0] msg, input int len);
    logic [511:0] blk;
    logic [63:0]  bits;
    blk  = '0;
    bits = 64'(8 * len);
    for (int i = 0; i < len; i++) blk[511-8*i -: 8] = msg[8*(len-1-i) +: 8];
    blk[511-8*len -: 8] = 8'h80;
    for (int j = 0; j < 8; j++) blk[511-8*(56+j) -: 8] = bits[8*j +: 8];
    return blk;
  endfunction

  function automatic logic [127:0] md5_blk(input logic [511:0] blk);
    logic [31:0] m[16];
    logic [31:0] a, b, c, d, f, r;
    int g, s;
    for (int j = 0; j < 16; j++)
      m[j] = {blk[511-8*(4*j+3) -: 8], blk[511-8*(4*j+2) -: 8],
              blk[511-8*(4*j+1) -: 8], blk[511-8*(4*j) -: 8]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;               end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16;  end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16;  end
      else             begin f = c ^ (b | ~d);       g = (7*i) % 16;      end
      f = f + a + K_TAB[i] + m[g];
      s = S_TAB[(i/16)*4 + (i%4)];
      r = (f << s) | (f >> (32 - s));
      a = d; d = c; c = b; b = b + r;
    end
    a = a + 32'h67452301; b = b + 32'hefcdab89; c = c + 32'h98badcfe; d = d + 32'h10325476;
    return {bswap(a), bswap(b), bswap(c), bswap(d)};
  endfunction

  // Core stand-in: digest and padded block appear LAT cycles after core_message is registered.
  always @(posedge clk) begin
    logic [511:0] blk;
    blk = build_block(core_message, int'(core_length[6:3]));
    for (int i = LAT - 1; i > 0; i--) begin
      h_pipe[i] <= h_pipe[i-1];
      m_pipe[i] <= m_pipe[i-1];
    end
    m_pipe[0] <= blk;
    if (force_en && (core_message[63:0] == force_a || core_message[63:0] == force_b))
      h_pipe[0] <= force_tgt;
    else
      h_pipe[0] <= md5_blk(blk);
  end

  assign core_hash    = h_pipe[LAT-1];
  assign core_msg_out = m_pipe[LAT-1];

  // Candidate k of the enumeration: digit j (byte j) = lo + (k / R^j) mod R.
  function automatic logic [63:0] cand(input int k, input int len, input int lo, input int hi);
    logic [63:0] v;
    int r, q;
    v = '0; r = hi - lo + 1; q = k;
    for (int j = 0; j < len; j++) begin
      v[8*j +: 8] = 8'(lo + q % r);
      q = q / r;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs >= exp - 1 && obs <= exp + 1) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, exp);
  endtask

  task automatic run_search(input int len, input int lo, input int hi, input logic [127:0] tgt,
                            output int cyc);
    cfg_len = 4'(len); cfg_char_lo = 8'(lo); cfg_char_hi = 8'(hi); cfg_target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
    end
  endtask

  // k < 0 means no candidate's digest equals the target.
  task automatic search_case(input string tag, input int len, input int lo, input int hi,
                             input int k, input logic [127:0] tgt);
    int n, tried_e, cyc;
    n = 1;
    for (int j = 0; j < len; j++) n = n * (hi - lo + 1);
    tried_e = (k < 0) ? n : ((k + LAT + 1 < n) ? k + LAT + 1 : n);
    run_search(len, lo, hi, tgt, cyc);
    check({tag, "_done"}, 128'(done), 128'(1));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_found"}, 128'(found), 128'(k >= 0));
    check({tag, "_found_msg"}, 128'(found_msg), (k >= 0) ? 128'(cand(k, len, lo, hi)) : 128'(0));
    check({tag, "_tried"}, 128'(tried_count), 128'(tried_e));
    check({tag, "_cfg_err"}, 128'(cfg_err), 128'(0));
    check({tag, "_last_msg"}, 128'(core_message), 128'(cand(tried_e - 1, len, lo, hi)));
    check({tag, "_length"}, 128'(core_length), 128'(8 * len));
    check_near({tag, "_latency"}, cyc, tried_e + LAT + 2);
  endtask

  initial begin
    int cyc, len, lo, r, n, k, ka, kb;
    logic [127:0] tgt;
    logic [447:0] saved_msg;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_len = '0; cfg_char_lo = '0; cfg_char_hi = '0; cfg_target = '0;
    force_en = 1'b0; force_a = '0; force_b = '0; force_tgt = '0;
    #2;
    check("reset_outputs", {core_message[63:0], core_length, 6'(0)} | 128'({busy, done, found, cfg_err}),
          128'(0));
    check("reset_tried", 128'(tried_count), 128'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    search_case("abc", 3, 8'h61, 8'h63, 5, 128'h900150983cd24fb0d6963f7d28e17f72);

    // Illegal configs following a successful match; found must clear and nothing is issued.
    saved_msg = core_message;
    for (int t = 0; t < 3; t++) begin
      cfg_len     = (t == 0) ? 4'd0 : (t == 1) ? 4'd3 : 4'd9;
      cfg_char_lo = (t == 1) ? 8'h7a : 8'h61;
      cfg_char_hi = (t == 1) ? 8'h61 : 8'h7a;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 2) begin tick(); cyc++; end
      check("illegal_done", 128'(done), 128'(1));
      check("illegal_cfg_err", 128'(cfg_err), 128'(1));
      check("illegal_found", 128'(found), 128'(0));
      check("illegal_tried", 128'(tried_count), 128'(0));
      check("illegal_msg_kept", 128'(core_message), 128'(saved_msg));
      tick();
      check("illegal_busy", 128'(busy), 128'(0));
    end
    abort = 1'b1; tick(); abort = 1'b0; tick();
    check("abort_in_done", 128'({done, cfg_err, busy}), 128'(3'b110));

    search_case("exhaust", 1, 8'h62, 8'h7a, -1, 128'h0cc175b9c0f1b6a831c399e269772661);

    for (int it = 0; it < 4; it++) begin
      len = int'($urandom_range(3, 1));
      r   = (len == 1) ? int'($urandom_range(16, 2)) : (len == 2) ? int'($urandom_range(8, 2))
                                                     : int'($urandom_range(4, 2));
      lo  = int'($urandom_range(8'he0, 8'h20));
      n = 1;
      for (int j = 0; j < len; j++) n = n * r;
      k = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(n - 1, 0));
      if (k < 0) tgt = {$urandom, $urandom, $urandom, $urandom};
      else       tgt = md5_blk(build_block(448'(cand(k, len, lo, lo + r - 1)), len));
      search_case("random", len, lo, lo + r - 1, k, tgt);
    end

    // Two forced hits: the earlier one wins and issue halts on it.
    ka = int'($urandom_range(9, 0));
    kb = ka + int'($urandom_range(5, 1));
    force_tgt = {$urandom, $urandom, $urandom, $urandom};
    force_a = cand(ka, 2, 8'h30, 8'h39);
    force_b = cand(kb, 2, 8'h30, 8'h39);
    force_en = 1'b1;
    search_case("first_match", 2, 8'h30, 8'h39, ka, force_tgt);
    force_en = 1'b0;

    // Abort sampled on the 10th RUN edge; a start during DRAIN must be ignored.
    cfg_len = 4'd4; cfg_char_lo = 8'h00; cfg_char_hi = 8'hff;
    cfg_target = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    cyc = 10;
    repeat (5) begin tick(); cyc++; end
    cfg_len = 4'd1; cfg_char_lo = 8'h41; cfg_char_hi = 8'h42;
    start = 1'b1; tick(); start = 1'b0; cyc++;
    check("abort_busy_draining", 128'(busy), 128'(1));
    while (!done && cyc < 500) begin tick(); cyc++; end
    check("abort_done", 128'(done), 128'(1));
    check("abort_tried", 128'(tried_count), 128'(10));
    check("abort_found", 128'(found), 128'(0));
    check("abort_no_issue_after", 128'(core_message), 128'(9));
    check_near("abort_latency", cyc - 10, LAT + 2);

    // Reset mid-run while the target's digest is still in the pipeline.
    tgt = md5_blk(build_block(448'(cand(5, 2, 8'h61, 8'h6a)), 2));
    cfg_len = 4'd2; cfg_char_lo = 8'h61; cfg_char_hi = 8'h6a; cfg_target = tgt;
    start = 1'b1; tick(); start = 1'b0;
    repeat (29) tick();
    check("pre_reset_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midreset_flags", 128'({busy, done, found, cfg_err}), 128'(0));
    check("midreset_msg", 128'(core_message), 128'(0));
    check("midreset_len", 128'(core_length), 128'(0));
    check("midreset_tried_fmsg", {16'(0), tried_count, found_msg}, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    search_case("after_reset", 2, 8'h61, 8'h62, -1, tgt);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
